custom_intc: RTL

- Parametrised multi-line interrupt controller coprocessor. Successor to the 2-vector cop.
- Sits beside the core fetch stage. Latches rising edges on NUM_IRQ request lines and masks them per line.
- Selects the highest-priority pending line, presents its vector on ipc, and holds intrf until the core acknowledges.
- Saves the interrupted pc and returns it on exception-return.

---
 rtl/custom_intc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/custom_intc.sv
// custom_intc: multi-line interrupt controller with edge-latched pending bits, per-line masking,
// fixed-priority vector select and saved/return pc. Define INTC_NEST_EN to enable 2-deep preemption.
module custom_intc #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned VEC_BASE   = 128,
  parameter int unsigned VEC_STRIDE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic                  iack,
  input  logic                  ieret,
  output logic                  intrf,
  output logic [ADDR_WIDTH-1:0] ipc,
  output logic [2:0]            active_id,
  output logic                  in_service,
  output logic [NUM_IRQ-1:0]    pending,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [ADDR_WIDTH-1:0] rpc,
  output logic                  ret_valid
);

  localparam int unsigned IdW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_e;

  state_e                state_q;
  logic [NUM_IRQ-1:0]    irq_r_q;
  logic [NUM_IRQ-1:0]    pending_q;
  logic [NUM_IRQ-1:0]    pending_d;
  logic [NUM_IRQ-1:0]    mask_q;
  logic [NUM_IRQ-1:0]    cand_c;
  logic [NUM_IRQ-1:0]    clr_c;
  logic [IdW-1:0]        req_id_q;
  logic [IdW-1:0]        active_id_q;
  logic [IdW-1:0]        sel_id_c;
  logic                  sel_found_c;
  logic                  intrf_q;
  logic                  in_service_q;
  logic                  ret_valid_q;
  logic [ADDR_WIDTH-1:0] ipc_q;
  logic [ADDR_WIDTH-1:0] epc_q;
  logic [ADDR_WIDTH-1:0] rpc_q;

  function automatic logic [ADDR_WIDTH-1:0] vec_addr(input logic [IdW-1:0] id);
    return ADDR_WIDTH'(VEC_BASE + 32'(id) * VEC_STRIDE);
  endfunction

  // Lowest-index enabled pending line wins.
  always_comb begin
    cand_c      = pending_q & mask_q;
    sel_found_c = 1'b0;
    sel_id_c    = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (cand_c[i]) begin
        sel_found_c = 1'b1;
        sel_id_c    = IdW'(i);
      end
    end
  end

  // A new rising edge beats the acknowledge clear on the same line.
  always_comb begin
    clr_c     = (state_q == S_REQ && iack) ? (NUM_IRQ'(1) << req_id_q) : '0;
    pending_d = (pending_q & ~clr_c) | (irq & ~irq_r_q);
  end

`ifdef INTC_NEST_EN
  localparam int unsigned Depth = 2;

  logic [1:0]            depth_q;
  logic [ADDR_WIDTH-1:0] stk_epc_q [Depth];
  logic [IdW-1:0]        stk_id_q  [Depth];
  logic                  top_idx_c;
  logic                  preempt_c;

  assign top_idx_c = ~depth_q[0];
  assign preempt_c = sel_found_c && (sel_id_c < active_id_q) && (depth_q < 2'(Depth));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      irq_r_q      <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      req_id_q     <= '0;
      active_id_q  <= '0;
      intrf_q      <= 1'b0;
      in_service_q <= 1'b0;
      ret_valid_q  <= 1'b0;
      ipc_q        <= '0;
      epc_q        <= '0;
      rpc_q        <= '0;
`ifdef INTC_NEST_EN
      depth_q      <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        stk_epc_q[i] <= '0;
        stk_id_q[i]  <= '0;
      end
`endif
    end else begin
      irq_r_q     <= irq;
      pending_q   <= pending_d;
      ret_valid_q <= 1'b0;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      unique case (state_q)
        S_IDLE: begin
          if (sel_found_c) begin
            req_id_q <= sel_id_c;
            ipc_q    <= vec_addr(sel_id_c);
            intrf_q  <= 1'b1;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (iack) begin
`ifdef INTC_NEST_EN
            // Preempting an active handler: save its context first.
            if (in_service_q) begin
              stk_epc_q[depth_q[0]] <= epc_q;
              stk_id_q[depth_q[0]]  <= active_id_q;
              depth_q               <= depth_q + 2'd1;
            end
`endif
            epc_q        <= pc;
            active_id_q  <= req_id_q;
            in_service_q <= 1'b1;
            intrf_q      <= 1'b0;
            state_q      <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (ieret) begin
            rpc_q       <= epc_q;
            ret_valid_q <= 1'b1;
`ifdef INTC_NEST_EN
            if (depth_q != 2'd0) begin
              epc_q       <= stk_epc_q[top_idx_c];
              active_id_q <= stk_id_q[top_idx_c];
              depth_q     <= depth_q - 2'd1;
            end else begin
              in_service_q <= 1'b0;
              state_q      <= S_IDLE;
            end
`else
            in_service_q <= 1'b0;
            state_q      <= S_IDLE;
`endif
          end
`ifdef INTC_NEST_EN
          else if (preempt_c) begin
            req_id_q <= sel_id_c;
            ipc_q    <= vec_addr(sel_id_c);
            intrf_q  <= 1'b1;
            state_q  <= S_REQ;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign intrf      = intrf_q;
  assign ipc        = ipc_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign epc        = epc_q;
  assign rpc        = rpc_q;
  assign ret_valid  = ret_valid_q;

endmodule
